// File: rtl/act_interp_lut.sv
// act_interp_lut: three-stage interpolating activation table behind a valid/ready stream.
// Define ACT_LUT_WRITE_EN for a run-time writable table (adds wr_en/wr_addr/wr_data ports).
module act_interp_lut #(
    parameter int IN_W   = 8,
    parameter int ADDR_W = 4,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data
`ifdef ACT_LUT_WRITE_EN
    ,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [OUT_W-1:0]  wr_data
`endif
);
    localparam int FRAC_W = IN_W - ADDR_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int PW     = OUT_W + FRAC_W + 2;
    localparam logic [ADDR_W-1:0]    IDX_P = ADDR_W'((2 ** (ADDR_W - 1)) - 1);
    localparam logic signed [PW-1:0] SMAX  = PW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PW-1:0] SMIN  = ~SMAX;

    function automatic logic [OUT_W-1:0] ramp(input logic [ADDR_W-1:0] i);
        logic [OUT_W-1:0] v;
        v = '0;
        v[OUT_W-1 -: ADDR_W] = i;
        return v;
    endfunction

    logic                     advance;
    logic [ADDR_W-1:0]        idx;
    logic [ADDR_W-1:0]        nidx;
    logic [FRAC_W-1:0]        frac;
    logic [OUT_W-1:0]         base_c;
    logic [OUT_W-1:0]         next_c;
    logic                     v1;
    logic                     v2;
    logic signed [OUT_W-1:0]  base1;
    logic signed [OUT_W-1:0]  next1;
    logic [FRAC_W-1:0]        frac1;
    logic signed [OUT_W-1:0]  base2;
    logic signed [PW-1:0]     prod2;
    logic signed [OUT_W:0]    delta_c;
    logic signed [PW-1:0]     prod_c;
    logic signed [PW-1:0]     sum_c;
    logic [OUT_W-1:0]         sat_c;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign idx      = in_data[IN_W-1 -: ADDR_W];
    assign frac     = in_data[FRAC_W-1:0];
    // idx+1 already wraps -1 to 0; only the top positive index needs clamping
    assign nidx     = (idx == IDX_P) ? IDX_P : idx + ADDR_W'(1);

`ifdef ACT_LUT_WRITE_EN
    logic [OUT_W-1:0] lut [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                lut[i] <= ramp(ADDR_W'(i));
            end
        end else if (wr_en) begin
            lut[wr_addr] <= wr_data;
        end
    end

    assign base_c = lut[idx];
    assign next_c = lut[nidx];
`else
    assign base_c = ramp(idx);
    assign next_c = ramp(nidx);
`endif

    always_comb begin
        delta_c = (OUT_W + 1)'(next1) - (OUT_W + 1)'(base1);
        prod_c  = PW'(delta_c) * $signed(PW'(frac1));
        sum_c   = PW'(base2) + (prod2 >>> FRAC_W);
        if (sum_c > SMAX) begin
            sat_c = SMAX[OUT_W-1:0];
        end else if (sum_c < SMIN) begin
            sat_c = SMIN[OUT_W-1:0];
        end else begin
            sat_c = sum_c[OUT_W-1:0];
        end
    end

    // All stages share one enable, so bubbles keep their positions through a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            base1     <= '0;
            next1     <= '0;
            frac1     <= '0;
            base2     <= '0;
            prod2     <= '0;
            out_data  <= '0;
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            if (in_valid) begin
                base1 <= base_c;
                next1 <= next_c;
                frac1 <= frac;
            end
            if (v1) begin
                base2 <= base1;
                prod2 <= prod_c;
            end
            if (v2) begin
                out_data <= sat_c;
            end
        end
    end
endmodule
